// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake and registered result/flags.
// Define ALU_SEQ_MUL_EN to make op 111 an iterative shift-add multiply.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic             rdy_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             v_q, v_d;

  logic             accept;
  logic             is_mul;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_v;

  // rdy_q keeps in_ready low through reset and until the first edge after it
  assign in_ready = rdy_q & ((state_q == IDLE) |
                             ((state_q == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign carry     = c_q;
  assign zero      = z_q;
  assign neg       = n_q;
  assign ovf       = v_q;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      3'b000: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) &&
                (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        alu_r = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) &&
                (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010: alu_r = a & b;
      3'b011: alu_r = a ^ b;
      3'b100: alu_r = a | b;
      3'b101: begin
        alu_r = {a[WIDTH-2:0], 1'b0};
        alu_c = a[WIDTH-1];
      end
      3'b110: begin
        alu_r = {1'b0, a[WIDTH-1:1]};
        alu_c = a[0];
      end
      default: ;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, mc_q, acc_n;
  logic [WIDTH-1:0]   mp_q;
  logic [CW-1:0]      cnt_q;
  logic               mul_last;

  assign is_mul   = (op == 3'b111);
  assign acc_n    = acc_q + (mp_q[0] ? mc_q : '0);
  assign mul_last = (state_q == BUSY) && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      mc_q  <= '0;
      mp_q  <= '0;
      cnt_q <= '0;
    end else if (accept && is_mul) begin
      acc_q <= '0;
      mc_q  <= {{WIDTH{1'b0}}, a};
      mp_q  <= b;
      cnt_q <= '0;
    end else if (state_q == BUSY) begin
      acc_q <= acc_n;
      mc_q  <= mc_q << 1;
      mp_q  <= mp_q >> 1;
      cnt_q <= cnt_q + CW'(1);
    end
  end
`else
  assign is_mul = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = is_mul ? BUSY : DONE;
      end
      DONE: begin
        if (accept)         state_d = is_mul ? BUSY : DONE;
        else if (out_ready) state_d = IDLE;
      end
      BUSY: begin
`ifdef ALU_SEQ_MUL_EN
        if (mul_last) state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (accept && !is_mul) begin
      res_d = alu_r;
      c_d   = alu_c;
      z_d   = (alu_r == '0);
      n_d   = alu_r[WIDTH-1];
      v_d   = alu_v;
    end
`ifdef ALU_SEQ_MUL_EN
    if (mul_last) begin
      res_d = acc_n[WIDTH-1:0];
      c_d   = |acc_n[2*WIDTH-1:WIDTH];
      z_d   = (acc_n[WIDTH-1:0] == '0);
      n_d   = acc_n[WIDTH-1];
      v_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      res_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      res_q   <= res_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed corner cases,
// backpressure, reset, and a randomized stream against a scoreboard.
module tb_alu_seq;

  localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         neg;
  logic         ovf;

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
  } res_t;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero),
    .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  function automatic res_t model(input int o, input int x, input int y);
    res_t e;
    int   r, s;
    r = 0;
    e = '0;
    case (o)
      0: begin
        r = (x + y) % 256;
        e.c = (x + y) > 255;
        s = sgn(x) + sgn(y);
        e.v = (s > 127) || (s < -128);
      end
      1: begin
        r = (x - y + 256) % 256;
        e.c = x < y;
        s = sgn(x) - sgn(y);
        e.v = (s > 127) || (s < -128);
      end
      2: r = x & y;
      3: r = x ^ y;
      4: r = x | y;
      5: begin r = (x * 2) % 256; e.c = x > 127; end
      6: begin r = x / 2; e.c = (x % 2) == 1; end
      default: begin
        if (MUL_EN) begin
          r = (x * y) % 256;
          e.c = (x * y) > 255;
        end
      end
    endcase
    e.r = 8'(r);
    e.z = (r == 0);
    e.n = r > 127;
    return e;
  endfunction

  function automatic int exp_lat(input int o);
    return (o == 7 && MUL_EN) ? W + 1 : 1;
  endfunction

  // Entered and left #1 after a rising edge with the DUT idle.
  task automatic run_op(input int o, input int x, input int y,
                        input int stall);
    res_t e;
    int   lat;
    e = model(o, x, y);
    op = 3'(o);
    a = 8'(x);
    b = 8'(y);
    in_valid = 1'b1;
    out_ready = 1'b0;
    #1 chk("accept_rdy", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("busy_rdy", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, exp_lat(o));
    chk("res", 32'({result, carry, zero, neg, ovf}), 32'(e));
    repeat (stall) begin
      @(posedge clk);
      #1;
      chk("hold", 32'({out_valid, in_ready, result, carry, zero, neg, ovf}),
          32'({2'b10, e}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("drain", 32'(out_valid), 0);
  endtask

  res_t q[$];

  initial begin
    res_t e;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    op = '0;
    #1;
    chk("rst_state", 32'({out_valid, in_ready, result, carry, zero, neg, ovf}),
        0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rdy_after_rst", 32'(in_ready), 1);

    run_op(0, 8'hFF, 8'h01, 0);
    run_op(0, 8'h7F, 8'h01, 1);
    run_op(1, 8'h03, 8'h05, 0);
    run_op(5, 8'h81, 8'h00, 0);
    run_op(6, 8'h81, 8'h00, 2);
    run_op(7, 8'h10, 8'h11, 1);
    run_op(1, 8'h80, 8'h01, 0);
    run_op(2, 8'hF0, 8'h3C, 0);

    // Stalled xor, then release and accept a new add in the same cycle
    run_op(3, 8'hAA, 8'h55, 5);
    op = 3'd3;
    a = 8'hAA;
    b = 8'h55;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1 chk("bp_hold", 32'({out_valid, in_ready, result}), 32'({2'b10, 8'hFF}));
    end
    out_ready = 1'b1;
    op = 3'd0;
    a = 8'h12;
    b = 8'h34;
    in_valid = 1'b1;
    #1 chk("bp_rdy", 32'(in_ready), 1);
    @(posedge clk);
    #1 chk("no_bubble", 32'({out_valid, result}), 32'({1'b1, 8'h46}));
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Reset while a result is being presented
    op = 3'd0;
    a = 8'h7F;
    b = 8'h01;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("pre_rst", 32'({out_valid, result}), 32'({1'b1, 8'h80}));
    rst_n = 1'b0;
    #1;
    chk("mid_rst", 32'({out_valid, in_ready, result, carry, zero, neg, ovf}),
        0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_release", 32'({in_ready, out_valid}), 32'(2'b10));

    if (MUL_EN) begin
      op = 3'd7;
      a = 8'h0F;
      b = 8'h0F;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1 chk("busy_discard", 32'({out_valid, in_ready}), 32'(2'b01));
    end

    for (int i = 0; i < 20; i++)
      run_op($urandom_range(0, 7), $urandom_range(0, 255),
             $urandom_range(0, 255), $urandom_range(0, 2));

    // Random stream: one result in flight, checked against a queue
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      #1;
      if (out_valid) begin
        chk("sb_nonempty", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          chk("sb_res", 32'({result, carry, zero, neg, ovf}), 32'(q[0]));
          if (out_ready) e = q.pop_front();
        end
      end
      if (in_valid && in_ready)
        q.push_back(model(int'(op), int'(a), int'(b)));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      if (out_valid) begin
        chk("sb_drain", 32'({result, carry, zero, neg, ovf}), 32'(q[0]));
        e = q.pop_front();
      end
      @(posedge clk);
      #1;
    end
    chk("sb_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 in_valid  input  1  request present on a, b, op.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 op  input  3  operation select (see REQ-012).
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 result  output  WIDTH; carry, zero, neg, ovf  output  1 each; registered flags.

Function
REQ-012 op encodings: 000 add; 001 sub (a-b); 010 and; 011 xor; 100 or; 101 shl by 1; 110 shr (logical) by 1; 111 mul (REQ-026).
REQ-013 The block SHALL hold three states: IDLE, BUSY, DONE.
REQ-014 Accept = in_valid & in_ready on a rising edge; a, b, op SHALL be captured at accept.
REQ-015 in_ready SHALL be 1 in IDLE, or in DONE when out_ready=1; 0 in BUSY.
REQ-016 Single-cycle ops SHALL go IDLE/DONE -> DONE, with out_valid=1 the cycle after accept (latency 1).
REQ-017 out_valid SHALL equal (state==DONE); result and flags SHALL stay stable while out_valid=1 and out_ready=0.
REQ-018 DONE with out_ready=1 and no accept -> IDLE; with accept -> DONE (single-cycle op) or BUSY (mul); back-to-back throughput one op per cycle.
REQ-019 add: result = (a+b) mod 2^WIDTH; carry = bit WIDTH of the WIDTH+1-bit sum.
REQ-020 sub: result = (a-b) mod 2^WIDTH; carry = 1 iff a<b unsigned (borrow).
REQ-021 ovf: add, 1 iff a, b share sign and result sign differs; sub, 1 iff a, b differ in sign and result sign differs from a; 0 for all other ops.
REQ-022 and/xor/or: carry=0.
REQ-023 shl: result={a[WIDTH-2:0],0}, carry=a[WIDTH-1]; shr: result={0,a[WIDTH-1:1]}, carry=a[0].
REQ-024 zero = (result==0); neg = result[WIDTH-1]; for every op.
REQ-025 in_valid while in_ready=0 SHALL be ignored (not queued).

Reset
REQ-030 rst_n=0 SHALL asynchronously force state=IDLE, result=0, carry=0, zero=0, neg=0, ovf=0, out_valid=0, in_ready=0.
REQ-031 in_ready SHALL be 1 from the first edge after rst_n deasserts; reset during BUSY or DONE SHALL discard the operation with no output.

Configuration
REQ-026 Macro ALU_SEQ_MUL_EN defined: op 111 = unsigned iterative shift-add multiply; accept -> BUSY for exactly WIDTH cycles -> DONE; out_valid WIDTH+1 cycles after accept; result = low WIDTH bits of a*b; carry = 1 iff high WIDTH bits nonzero; ovf=0.
REQ-027 ALU_SEQ_MUL_EN undefined: op 111 SHALL be single-cycle with result=0, carry=0, ovf=0, zero=1, neg=0; BUSY unreachable; no multiplier/counter logic synthesised.
REQ-028 All other ops SHALL behave identically with or without the macro.

Verification (WIDTH=8)
REQ-040 Reset mid-stream: rst_n low for 1 cycle during out_valid=1 -> out_valid=0, result=0, all flags 0 immediately; in_ready=1 after release.
REQ-041 add a=0xFF b=0x01 -> result 0x00, carry 1, zero 1, neg 0, ovf 0; add a=0x7F b=0x01 -> 0x80, carry 0, neg 1, ovf 1.
REQ-042 sub a=0x03 b=0x05 -> 0xFE, carry 1, neg 1; shl a=0x81 -> 0x02, carry 1; shr a=0x81 -> 0x40, carry 1.
REQ-043 Backpressure: xor a=0xAA b=0x55, out_ready=0 for 5 cycles -> result 0xFF held, in_ready 0; out_ready=1 with new add same cycle -> new result next cycle, no bubble.
REQ-044 With ALU_SEQ_MUL_EN: mul a=0x10 b=0x11 -> out_valid exactly 9 cycles after accept, result 0x10, carry 1, in_ready 0 throughout BUSY; without macro: result 0x00, zero 1, latency 1.
